// File: rtl/risc_controller_pkg.sv
// -----------------------------------------------------------------------------
// risc_controller_pkg
// Shared definitions for the 5-bit-address RISC CPU control path: opcode and
// phase encodings, inc_pc codes and small decode helpers. The program counter
// and instruction register import the same package so that every block
// agrees on the encodings.
// Build option: CTRL_SINGLE_STEP_EN (used by risc_controller only).
// -----------------------------------------------------------------------------
package risc_controller_pkg;

    localparam int OPC_W = 3;   // opcode width, fixed by the ISA
    localparam int INC_W = 2;   // inc_pc code width

    // Instruction opcodes
    typedef enum logic [OPC_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    // Instruction phases, one clock each
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Program counter increment codes
    localparam logic [INC_W-1:0] INC_NONE = 2'd0;
    localparam logic [INC_W-1:0] INC_ONE  = 2'd1;
    localparam logic [INC_W-1:0] INC_SKIP = 2'd2;

    // Instructions that read an operand and load the accumulator
    function automatic logic is_aluop(input opcode_e op);
        logic res;
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_LDA: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

    // Successor phase; STORE wraps back to INST_ADDR
    function automatic phase_e next_phase(input phase_e ph);
        return phase_e'(ph + 3'd1);
    endfunction

endpackage

// File: rtl/risc_controller_if.sv
// -----------------------------------------------------------------------------
// risc_controller_if
// Control bundle between the instruction sequencer and the CPU datapath.
//   opcode  : IR opcode field        (datapath -> controller)
//   zero    : accumulator==0 flag    (datapath -> controller)
//   sel, rd, ld_ir, halt, ld_pc, inc_pc, ld_ac, wr, data_e, phase
//           : control strobes/trace  (controller -> datapath)
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface risc_controller_if;
    import risc_controller_pkg::*;

    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             sel;
    logic             rd;
    logic             ld_ir;
    logic             halt;
    logic             ld_pc;
    logic [INC_W-1:0] inc_pc;
    logic             ld_ac;
    logic             wr;
    logic             data_e;
    logic [2:0]       phase;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, halt, ld_pc, inc_pc, ld_ac, wr, data_e, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, halt, ld_pc, inc_pc, ld_ac, wr, data_e, phase
    );

endinterface

// File: rtl/risc_controller.sv
// -----------------------------------------------------------------------------
// risc_controller
// 8-phase instruction sequencer for the 5-bit-address RISC CPU. One
// instruction takes 8 clocks; the control strobes are a Moore decode of the
// phase register and the opcode/zero values captured during the instruction.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   step   : single-step request (only with CTRL_SINGLE_STEP_EN defined)
//   bus    : risc_controller_if.master (opcode/zero in, control strobes out)
// Build option CTRL_SINGLE_STEP_EN: the sequencer parks in INST_ADDR until
// step is sampled high, then runs exactly one instruction.
// -----------------------------------------------------------------------------
module risc_controller
    import risc_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic               step,
`endif
    risc_controller_if.master  bus
);

    phase_e  phase_r;
    opcode_e op_r;
    logic    zero_r;
    logic    halted_r;
    logic    run_s;

    logic             sel_s;
    logic             rd_s;
    logic             ld_ir_s;
    logic             halt_s;
    logic             ld_pc_s;
    logic [INC_W-1:0] inc_pc_s;
    logic             ld_ac_s;
    logic             wr_s;
    logic             data_e_s;
    logic             alu_s;

    // Permission to leave INST_ADDR; later phases never stall
    always_comb begin
`ifdef CTRL_SINGLE_STEP_EN
        run_s = (phase_r != PH_INST_ADDR) || step;
`else
        run_s = 1'b1;
`endif
    end

    // Phase sequencer with opcode/zero capture and halt latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r  <= PH_INST_ADDR;
            op_r     <= OP_HLT;
            zero_r   <= 1'b0;
            halted_r <= 1'b0;
        end else if (halted_r) begin
            // Only rst_n leaves the halted state
            phase_r  <= phase_r;
        end else begin
            case (phase_r)
                PH_INST_ADDR: begin
                    if (run_s) begin
                        phase_r <= PH_INST_FETCH;
                    end else begin
                        phase_r <= PH_INST_ADDR;
                    end
                end
                PH_IDLE: begin
                    op_r <= opcode_e'(bus.opcode);
                    if (bus.opcode == OP_HLT) begin
                        // Freeze in IDLE; PC is never updated for HLT
                        halted_r <= 1'b1;
                        phase_r  <= PH_IDLE;
                    end else begin
                        phase_r  <= PH_OP_ADDR;
                    end
                end
                PH_OP_FETCH: begin
                    zero_r  <= bus.zero;
                    phase_r <= PH_ALU_OP;
                end
                default: begin
                    phase_r <= next_phase(phase_r);
                end
            endcase
        end
    end

    // Moore decode of the registered state into control strobes
    always_comb begin
        sel_s    = 1'b0;
        rd_s     = 1'b0;
        ld_ir_s  = 1'b0;
        halt_s   = 1'b0;
        ld_pc_s  = 1'b0;
        inc_pc_s = INC_NONE;
        ld_ac_s  = 1'b0;
        wr_s     = 1'b0;
        data_e_s = 1'b0;
        alu_s    = is_aluop(op_r);
        if (halted_r) begin
            sel_s  = 1'b1;
            halt_s = 1'b1;
        end else begin
            case (phase_r)
                PH_INST_ADDR: begin
                    sel_s = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel_s = 1'b1;
                    rd_s  = 1'b1;
                end
                PH_INST_LOAD: begin
                    sel_s   = 1'b1;
                    rd_s    = 1'b1;
                    ld_ir_s = 1'b1;
                end
                PH_IDLE: begin
                    // Opcode is live from the IR here, not yet captured
                    sel_s  = 1'b1;
                    rd_s   = 1'b1;
                    halt_s = (bus.opcode == OP_HLT);
                end
                PH_OP_ADDR: begin
                    sel_s = 1'b0;
                end
                PH_OP_FETCH: begin
                    rd_s = alu_s;
                end
                PH_ALU_OP: begin
                    rd_s     = alu_s;
                    data_e_s = (op_r == OP_STO);
                end
                PH_STORE: begin
                    rd_s     = alu_s;
                    ld_ac_s  = alu_s;
                    wr_s     = (op_r == OP_STO);
                    data_e_s = (op_r == OP_STO);
                    ld_pc_s  = (op_r == OP_JMP);
                    // JMP loads the PC instead of incrementing it
                    if (op_r == OP_JMP) begin
                        inc_pc_s = INC_NONE;
                    end else if ((op_r == OP_SKZ) && zero_r) begin
                        inc_pc_s = INC_SKIP;
                    end else begin
                        inc_pc_s = INC_ONE;
                    end
                end
                default: begin
                    sel_s = 1'b1;
                end
            endcase
        end
    end

    assign bus.sel    = sel_s;
    assign bus.rd     = rd_s;
    assign bus.ld_ir  = ld_ir_s;
    assign bus.halt   = halt_s;
    assign bus.ld_pc  = ld_pc_s;
    assign bus.inc_pc = inc_pc_s;
    assign bus.ld_ac  = ld_ac_s;
    assign bus.wr     = wr_s;
    assign bus.data_e = data_e_s;
    assign bus.phase  = phase_r;

endmodule

// File: tb/tb_risc_controller.sv
// -----------------------------------------------------------------------------
// tb_risc_controller
// Self-checking bench for risc_controller: directed instruction scenarios
// with literal expectations, followed by randomized opcode/zero/reset (and
// step, with CTRL_SINGLE_STEP_EN) traffic compared every cycle against an
// instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_risc_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic step = 1'b0;

    risc_controller_if bus ();

    risc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef CTRL_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model ----------------
    int       m_ph   = 0;
    logic [2:0] m_op = 3'd0;
    logic     m_z    = 1'b0;
    logic     m_halt = 1'b0;

`ifdef CTRL_SINGLE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    // Model state: phase counter, captured opcode/zero, halt flag
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_op <= 3'd0; m_z <= 1'b0; m_halt <= 1'b0;
        end else if (!m_halt) begin
            if (m_ph == 3) begin
                m_op <= bus.opcode;
                if (bus.opcode == 3'd0) m_halt <= 1'b1;
                else m_ph <= 4;
            end else if (m_ph == 0) begin
                if (!STEP_MODE || step) m_ph <= 1;
            end else begin
                if (m_ph == 5) m_z <= bus.zero;
                m_ph <= (m_ph + 1) % 8;
            end
        end
    end

    // Expected {sel,rd,ld_ir,halt,ld_pc,inc_pc[1:0],ld_ac,wr,data_e,phase[2:0]}
    function automatic logic [12:0] expect_out(int ph, logic [2:0] live, logic [2:0] op,
                                               logic z, logic hl);
        logic sel = 0, rd = 0, ldir = 0, halt = 0, ldpc = 0, ldac = 0, wr = 0, de = 0;
        logic [1:0] inc = 2'd0;
        logic [2:0] p3;
        logic alu;
        alu = (op >= 3'd2) && (op <= 3'd5);
        p3 = ph[2:0];
        if (hl) begin
            sel = 1; halt = 1;
        end else if (ph <= 3) begin
            sel = 1; rd = (ph != 0); ldir = (ph == 2); halt = (ph == 3) && (live == 3'd0);
        end else begin
            rd = alu && (ph >= 5);
            de = (op == 3'd6) && (ph >= 6);
            if (ph == 7) begin
                ldac = alu; wr = (op == 3'd6); ldpc = (op == 3'd7);
                inc = (op == 3'd7) ? 2'd0 : ((op == 3'd1) && z) ? 2'd2 : 2'd1;
            end
        end
        return {sel, rd, ldir, halt, ldpc, inc, ldac, wr, de, p3};
    endfunction

    function automatic logic [12:0] dut_out();
        return {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.ld_pc, bus.inc_pc,
                bus.ld_ac, bus.wr, bus.data_e, bus.phase};
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            logic [12:0] e, a;
            e = expect_out(m_ph, bus.opcode, m_op, m_z, m_halt);
            a = dut_out();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, a, e);
            end
            total++;
            if (bus.ld_pc === 1'b1 && bus.inc_pc !== 2'd0) begin
                bad++;
                $display("FAIL ldpc_inc_excl actual inc_pc=%0d required 0", bus.inc_pc);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // Run one instruction starting in phase 0 with literal checks
    task automatic do_instr(input logic [2:0] op, input logic z5, input logic z6,
                            input int exp_inc, input int exp_ldpc, input int exp_wr,
                            input int exp_de, input int exp_ldac, input int exp_rd7);
        bus.opcode = op;
        bus.zero   = z5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("phase_seq", bus.phase, i);
            chk("sel", bus.sel, (i < 4) ? 1 : 0);
            chk("ld_ir", bus.ld_ir, (i == 2) ? 1 : 0);
            if (i < 7) begin
                chk("wr_early", bus.wr, 0);
                chk("inc_early", bus.inc_pc, 0);
            end
            if (i == 6) begin
                chk("data_e_ph6", bus.data_e, exp_de);
                bus.zero = z6;
            end
            if (i == 7) begin
                chk("inc_pc_ph7", bus.inc_pc, exp_inc);
                chk("ld_pc_ph7", bus.ld_pc, exp_ldpc);
                chk("wr_ph7", bus.wr, exp_wr);
                chk("ld_ac_ph7", bus.ld_ac, exp_ldac);
                chk("rd_ph7", bus.rd, exp_rd7);
            end
        end
    endtask

    int hcnt;

    initial begin
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;
        step       = STEP_MODE;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk); #1;
        chk("rst_phase", bus.phase, 0);
        chk("rst_sel", bus.sel, 1);
        chk("rst_rd", bus.rd, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //       op    z5 z6 inc ldpc wr de ldac rd7
        do_instr(3'd2, 0, 0, 1,  0,   0, 0, 1,   1);   // ADD
        do_instr(3'd1, 1, 0, 2,  0,   0, 0, 0,   0);   // SKZ zero=1
        do_instr(3'd1, 0, 1, 1,  0,   0, 0, 0,   0);   // SKZ zero=0, late zero ignored
        do_instr(3'd7, 0, 0, 0,  1,   0, 0, 0,   0);   // JMP
        do_instr(3'd6, 0, 0, 1,  0,   1, 1, 0,   0);   // STO

        // HLT: freeze in phase 3
        bus.opcode = 3'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
        end
        chk("halt_ph3", bus.halt, 1);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk); #1;
            chk("halted_phase", bus.phase, 3);
            chk("halted_halt", bus.halt, 1);
            chk("halted_quiet", {bus.rd, bus.wr, bus.ld_pc, bus.inc_pc}, 0);
        end
        rst_n = 1'b0; #1;
        chk("hlt_rst_phase", bus.phase, 0);
        chk("hlt_rst_halt", bus.halt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of STO phase 6
        bus.opcode = 3'd6;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
        end
        chk("sto_ph6_de", bus.data_e, 1);
        rst_n = 1'b0;
        step  = 1'b0;
        #1;
        chk("abort_wr", bus.wr, 0);
        chk("abort_de", bus.data_e, 0);
        chk("abort_phase", bus.phase, 0);
        chk("abort_sel", bus.sel, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef CTRL_SINGLE_STEP_EN
        bus.opcode = 3'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("step_wait", bus.phase, 0);
        end
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk); #1;
            chk("step_run", bus.phase, i);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("step_park", bus.phase, 0);
        end
`else
        @(negedge clk); #1;
        chk("free_run", bus.phase, 0);
`endif

        // Randomized traffic checked by the compare process
        hcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ((m_halt && hcnt >= 22) || ($urandom_range(0, 299) == 0)) begin
                rst_n = 1'b0;
                hcnt  = 0;
            end
            if (m_halt) hcnt++;
            bus.opcode = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            step       = STEP_MODE ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk); #1;
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
